// File: rtl/fcc_regs_pkg.sv
// Shared constants, state enums and write-request struct for the FHT register file.
package fcc_regs_pkg;

  localparam int NUM_CFG = 4;

  localparam logic [2:0] REG_CFG0   = 3'd0;
  localparam logic [2:0] REG_CFG1   = 3'd1;
  localparam logic [2:0] REG_CFG2   = 3'd2;
  localparam logic [2:0] REG_CFG3   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  // One committed write: word index, data and byte strobes.
  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_req_t;

endpackage

// File: rtl/fcc_axil_wr_ctrl.sv
// AW/W join and B channel: AW and W may arrive in either order; the write
// commits on the edge where both are available, then waits for BREADY.
module fcc_axil_wr_ctrl
  import fcc_regs_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [AW-1:0] awaddr_i,
  input  logic          awvalid_i,
  output logic          awready_o,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wstrb_i,
  input  logic          wvalid_i,
  output logic          wready_o,
  output logic          bvalid_o,
  input  logic          bready_i,
  output logic          commit_o,
  output wr_req_t       req_o
);

  wr_state_e   state_q, state_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [2:0]  idx_q;
  logic [31:0] data_q;
  logic [3:0]  strb_q;
  logic        aw_fire, w_fire;
  logic        unused;

  assign unused    = ^awaddr_i[1:0];
  assign awready_o = en_i && (state_q == W_IDLE) && !aw_held_q;
  assign wready_o  = en_i && (state_q == W_IDLE) && !w_held_q;
  assign aw_fire   = awvalid_i && awready_o;
  assign w_fire    = wvalid_i && wready_o;
  assign bvalid_o  = (state_q == W_RESP);

  // Held flags are only ever set in W_IDLE, so this cannot fire in W_RESP.
  assign commit_o   = (aw_held_q || aw_fire) && (w_held_q || w_fire);
  assign req_o.idx  = aw_held_q ? idx_q  : awaddr_i[4:2];
  assign req_o.data = w_held_q  ? data_q : wdata_i;
  assign req_o.strb = w_held_q  ? strb_q : wstrb_i;

  // Next state and held-flag bookkeeping.
  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q || aw_fire;
    w_held_d  = w_held_q || w_fire;
    case (state_q)
      W_IDLE: if (commit_o) begin
        state_d   = W_RESP;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
      end
      W_RESP: if (bready_i) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  // State, held flags and the latched address/data of a half-arrived write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      if (aw_fire) idx_q <= awaddr_i[4:2];
      if (w_fire) begin
        data_q <= wdata_i;
        strb_q <= wstrb_i;
      end
    end
  end

endmodule

// File: rtl/fcc_axil_regs.sv
// AXI4-Lite slave: four RW config words, one RO status word, update strobe.
module fcc_axil_regs
  import fcc_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg3,
  output logic                            cfg_update,
  input  logic                            core_busy,
  input  logic                            core_done
);

  logic                     rst_done_q;
  logic [NUM_CFG-1:0][31:0] cfg_q;
  logic                     cfg_update_q;
  logic                     done_q;
  rd_state_e                rd_state_q, rd_state_d;
  logic [31:0]              rdata_q, rd_word, status;
  logic [2:0]               ar_idx;
  logic                     ar_fire, commit;
  wr_req_t                  wr_req;
  logic                     unused;

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0]};

  fcc_axil_wr_ctrl #(.AW(C_S_AXI_ADDR_WIDTH)) u_wr (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .en_i      (rst_done_q),
    .awaddr_i  (S_AXI_AWADDR),
    .awvalid_i (S_AXI_AWVALID),
    .awready_o (S_AXI_AWREADY),
    .wdata_i   (S_AXI_WDATA),
    .wstrb_i   (S_AXI_WSTRB),
    .wvalid_i  (S_AXI_WVALID),
    .wready_o  (S_AXI_WREADY),
    .bvalid_o  (S_AXI_BVALID),
    .bready_i  (S_AXI_BREADY),
    .commit_o  (commit),
    .req_o     (wr_req)
  );

  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RVALID  = (rd_state_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_ARREADY = rst_done_q && (rd_state_q == R_IDLE);
  assign ar_fire       = S_AXI_ARVALID && S_AXI_ARREADY;
  assign ar_idx        = S_AXI_ARADDR[4:2];

  assign cfg_reg0   = cfg_q[0];
  assign cfg_reg1   = cfg_q[1];
  assign cfg_reg2   = cfg_q[2];
  assign cfg_reg3   = cfg_q[3];
  assign cfg_update = cfg_update_q;

  // Read mux over pre-update contents, so a colliding write is not visible yet.
  always_comb begin
    status                = '0;
    status[STAT_BUSY_BIT] = core_busy;
    status[STAT_DONE_BIT] = done_q;
    rd_word               = '0;
    if (!ar_idx[2])                rd_word = cfg_q[ar_idx[1:0]];
    else if (ar_idx == REG_STATUS) rd_word = status;
  end

  // Read FSM next state.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (ar_fire) rd_state_d = R_DATA;
      R_DATA:  if (S_AXI_RREADY) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Ready gating after reset, read path, sticky done and update strobe.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rst_done_q   <= 1'b0;
      rd_state_q   <= R_IDLE;
      rdata_q      <= '0;
      done_q       <= 1'b0;
      cfg_update_q <= 1'b0;
    end else begin
      rst_done_q   <= 1'b1;
      rd_state_q   <= rd_state_d;
      if (ar_fire) rdata_q <= rd_word;
      // A coincident core_done beats the clearing read.
      done_q       <= core_done || (done_q && !(ar_fire && ar_idx == REG_STATUS));
      cfg_update_q <= commit && !wr_req.idx[2];
    end
  end

  // Byte-strobed update of the config words.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cfg_q <= '0;
    end else if (commit && !wr_req.idx[2]) begin
      for (int k = 0; k < 4; k++)
        if (wr_req.strb[k]) cfg_q[wr_req.idx[1:0]][k*8 +: 8] <= wr_req.data[k*8 +: 8];
    end
  end

endmodule

// File: tb/tb_fcc_axil_regs.sv
// Directed bench for the FHT AXI4-Lite register file.
module tb_fcc_axil_regs;

  logic        clk = 1'b0;
  logic        ARESETN;
  logic [4:0]  AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] cfg0, cfg1, cfg2, cfg3;
  logic        cfg_update, core_busy, core_done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fcc_axil_regs dut (
    .ACLK(clk), .ARESETN(ARESETN),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .cfg_reg0(cfg0), .cfg_reg1(cfg1), .cfg_reg2(cfg2), .cfg_reg3(cfg3),
    .cfg_update(cfg_update), .core_busy(core_busy), .core_done(core_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
  endtask

  // Full write with BREADY asserted; checks the B response.
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic ah, wh;
    int n;
    @(negedge clk);
    AWADDR = a; AWVALID = 1'b1; WDATA = d; WSTRB = s; WVALID = 1'b1; n = 0;
    while ((AWVALID || WVALID) && n < 20) begin
      ah = AWVALID && AWREADY;
      wh = WVALID && WREADY;
      @(negedge clk);
      if (ah) AWVALID = 1'b0;
      if (wh) WVALID = 1'b0;
      n++;
    end
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    while (!BVALID && n < 40) begin @(negedge clk); n++; end
    chk("bvalid", {31'b0, BVALID}, 32'd1);
    chk("bresp", {30'b0, BRESP}, 32'd0);
    @(negedge clk);
    BREADY = 1'b0;
  endtask

  // Full read; checks RVALID/RRESP and returns RDATA.
  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    logic ah;
    int n;
    @(negedge clk);
    ARADDR = a; ARVALID = 1'b1; n = 0;
    while (ARVALID && n < 20) begin
      ah = ARVALID && ARREADY;
      @(negedge clk);
      if (ah) ARVALID = 1'b0;
      n++;
    end
    ARVALID = 1'b0; RREADY = 1'b1;
    while (!RVALID && n < 40) begin @(negedge clk); n++; end
    chk("rvalid", {31'b0, RVALID}, 32'd1);
    chk("rresp", {30'b0, RRESP}, 32'd0);
    d = RDATA;
    @(negedge clk);
    RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] wv [4];
    wv[0] = 32'h0101FFFF; wv[1] = 32'habcd0001; wv[2] = 32'hdead0011; wv[3] = 32'hbeef0011;

    ARESETN = 1'b0; AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
    WDATA = '0; WSTRB = '0; core_busy = 1'b0; core_done = 1'b0;

    // reset state
    #251;
    chk("rst_awready", {31'b0, AWREADY}, 0);
    chk("rst_wready",  {31'b0, WREADY}, 0);
    chk("rst_arready", {31'b0, ARREADY}, 0);
    chk("rst_bvalid",  {31'b0, BVALID}, 0);
    chk("rst_rvalid",  {31'b0, RVALID}, 0);
    chk("rst_rdata",   RDATA, 0);
    chk("rst_cfg0",    cfg0, 0);
    chk("rst_update",  {31'b0, cfg_update}, 0);
    #249;
    @(negedge clk);
    ARESETN = 1'b1;
    chk("rel_awready_pre", {31'b0, AWREADY}, 0);
    @(negedge clk);
    chk("rel_awready", {31'b0, AWREADY}, 1);
    chk("rel_wready",  {31'b0, WREADY}, 1);
    chk("rel_arready", {31'b0, ARREADY}, 1);

    // basic write / read-back of words 0-3
    for (int i = 0; i < 4; i++) wr(5'(i * 4), wv[i], 4'hF);
    for (int i = 0; i < 4; i++) begin
      rd(5'(i * 4), r);
      chk($sformatf("rb_w%0d", i), r, wv[i]);
    end
    chk("cfg_reg0", cfg0, 32'h0101FFFF);
    chk("cfg_reg3", cfg3, 32'hbeef0011);
    wr(5'h14, 32'hFFFFFFFF, 4'hF);
    rd(5'h14, r);
    chk("w5_ignored", r, 0);

    // W three cycles ahead of AW
    @(negedge clk);
    WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge clk);
    WVALID = 1'b0;
    chk("wfirst_wready", {31'b0, WREADY}, 0);
    @(negedge clk);
    @(negedge clk);
    AWADDR = 5'h04; AWVALID = 1'b1;
    chk("wfirst_awready", {31'b0, AWREADY}, 1);
    chk("wfirst_bv_pre", {31'b0, BVALID}, 0);
    chk("wfirst_upd_pre", {31'b0, cfg_update}, 0);
    @(negedge clk);
    AWVALID = 1'b0;
    chk("wfirst_bvalid", {31'b0, BVALID}, 1);
    chk("wfirst_upd", {31'b0, cfg_update}, 1);
    chk("wfirst_cfg1", cfg1, 32'h12345678);
    @(negedge clk);
    chk("wfirst_upd_end", {31'b0, cfg_update}, 0);
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    chk("wfirst_bv_done", {31'b0, BVALID}, 0);
    chk("wfirst_upd_once", {31'b0, cfg_update}, 0);

    // byte strobes
    wr(5'h08, 32'hFFFFFFFF, 4'hF);
    wr(5'h08, 32'h00000000, 4'b0101);
    rd(5'h08, r);
    chk("strobe_w2", r, 32'hFF00FF00);

    // BREADY held low: back-pressure on AW/W
    @(negedge clk);
    AWADDR = 5'h0C; WDATA = 32'h55AA55AA; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge clk);
    WVALID = 1'b0; AWADDR = 5'h00;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_bvalid%0d", i),  {31'b0, BVALID}, 1);
      chk($sformatf("bp_awready%0d", i), {31'b0, AWREADY}, 0);
      chk($sformatf("bp_wready%0d", i),  {31'b0, WREADY}, 0);
      @(negedge clk);
    end
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    chk("bp_bv_done", {31'b0, BVALID}, 0);
    chk("bp_aw_open", {31'b0, AWREADY}, 1);
    WDATA = 32'h11111111; WVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("bp_second_bv", {31'b0, BVALID}, 1);
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    rd(5'h00, r);
    chk("bp_w0", r, 32'h11111111);
    rd(5'h0E, r);
    chk("bp_w3_unaligned", r, 32'h55AA55AA);

    // status word and sticky done
    @(negedge clk); core_done = 1'b1;
    @(negedge clk); core_done = 1'b0;
    rd(5'h10, r); chk("st_done", r, 32'h2);
    rd(5'h10, r); chk("st_clr", r, 32'h0);
    core_busy = 1'b1;
    rd(5'h10, r); chk("st_busy", r, 32'h1);
    @(negedge clk); core_done = 1'b1;
    @(negedge clk); core_done = 1'b0;
    ARADDR = 5'h10; ARVALID = 1'b1; core_done = 1'b1;
    chk("st_coin_arready", {31'b0, ARREADY}, 1);
    @(negedge clk);
    ARVALID = 1'b0; core_done = 1'b0; RREADY = 1'b1;
    chk("st_coin_rvalid", {31'b0, RVALID}, 1);
    chk("st_coin_rdata", RDATA, 32'h3);
    @(negedge clk);
    RREADY = 1'b0;
    rd(5'h10, r); chk("st_setwins", r, 32'h3);
    rd(5'h10, r); chk("st_after", r, 32'h1);
    core_busy = 1'b0;

    // reset while B and R are pending
    @(negedge clk);
    AWADDR = 5'h08; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 5'h00; ARVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    chk("mid_bvalid", {31'b0, BVALID}, 1);
    chk("mid_rvalid", {31'b0, RVALID}, 1);
    #2 ARESETN = 1'b0;
    #1;
    chk("mid_rst_bvalid", {31'b0, BVALID}, 0);
    chk("mid_rst_rvalid", {31'b0, RVALID}, 0);
    chk("mid_rst_rdata", RDATA, 0);
    chk("mid_rst_cfg2", cfg2, 0);
    @(negedge clk);
    @(negedge clk);
    ARESETN = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rd(5'(i * 4), r);
      chk($sformatf("post_rst_w%0d", i), r, 0);
    end
    rd(5'h18, r);
    chk("post_rst_w6", r, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fcc_axil_regs.md
# fcc_axil_regs

AXI4-Lite slave register file for the frequency calculation core. Terminates the S00_AXI port driven by the AXI4-Lite master. Holds four 32-bit read/write configuration words and one read-only status word, and presents them to the FHT datapath with a one-cycle write-update strobe. All responses are OKAY; the aligned write-then-read sequence on words 0–3 returns the written data.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; word index is addr[4:2].
- ACLK, in, 1, single clock; all logic is on the rising edge.
- ARESETN, in, 1, reset, asynchronous assert, active-low.
- S_AXI_AWADDR / AWPROT / AWVALID / AWREADY, in/in/in/out, 5/3/1/1, write address channel; AWPROT is ignored.
- S_AXI_WDATA / WSTRB / WVALID / WREADY, in/in/in/out, 32/4/1/1, write data channel.
- S_AXI_BRESP / BVALID / BREADY, out/out/in, 2/1/1, write response channel.
- S_AXI_ARADDR / ARPROT / ARVALID / ARREADY, in/in/in/out, 5/3/1/1, read address channel; ARPROT is ignored.
- S_AXI_RDATA / RRESP / RVALID / RREADY, out/out/out/in, 32/2/1/1, read data channel.
- cfg_reg0..cfg_reg3, out, 32 each, current register contents, to the core.
- cfg_update, out, 1, one-cycle pulse after any write to words 0–3.
- core_busy, in, 1, from the core.
- core_done, in, 1, single-cycle pulse from the core.

## Operation
- Map:
  - Words 0–3: RW.
  - Word 4: RO status. Bit0 = core_busy (live). Bit1 = done_sticky. Other bits are 0.
  - Words 5–7: read 0; writes are ignored.
- Write FSM, states W_IDLE, W_RESP:
  - In W_IDLE, AWREADY = !aw_held and WREADY = !w_held.
  - AW and W are accepted independently, in either order. Each is latched into aw_held/w_held.
  - When both are held (including same-cycle arrival), the write commits at that edge. The FSM moves to W_RESP with BVALID=1 and BRESP=00, and both held flags clear.
  - In W_RESP, AWREADY = WREADY = 0. On BVALID&&BREADY the FSM returns to W_IDLE.
- Byte strobes: byte k of the target word is updated only when WSTRB[k]=1. WSTRB=0 completes with OKAY and changes nothing.
- cfg_update is high for exactly the one cycle after a commit to words 0–3, independent of strobes.
- Read FSM, states R_IDLE, R_DATA:
  - In R_IDLE, ARREADY=1. On ARVALID the address is captured, RDATA is registered, and the FSM moves to R_DATA with RVALID=1 and RRESP=00.
  - In R_DATA, ARREADY=0 and RDATA is stable until RVALID&&RREADY, then the FSM returns to R_IDLE.
- done_sticky:
  - Set by core_done.
  - Cleared by the read handshake (ARVALID&&ARREADY) to word 4. The read returns the pre-clear value.
  - If core_done and the clearing read occur in the same cycle, the set wins.
- Read and write channels are concurrent. A same-cycle read and write commit to the same word returns the old value.

## Timing
- Reset values:
  - AWREADY=WREADY=ARREADY=0 during reset; each rises on the first edge after release.
  - BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0.
  - cfg_reg0..3=0, cfg_update=0, done_sticky=0, both FSMs idle, held flags clear.
- ARESETN low at any point (including mid-handshake) immediately forces the reset state. In-flight transactions are dropped.
- Write latency: commit edge N → BVALID high at N+1 → BVALID low the cycle after the BREADY handshake.
- Maximum write throughput: one write per 2 cycles with BREADY held high.
- Read latency: AR handshake at edge N → RVALID with data at N+1. Maximum throughput: one read per 2 cycles.
- Unaligned addresses: addr[1:0] is ignored.

## Structure
- Package fcc_regs_pkg holds:
  - Word indices: REG_CFG0..REG_CFG3 = 0..3, REG_STATUS = 4.
  - Status bit positions.
  - RESP_OKAY = 2'b00.
  - A write/read state enum.
- Sub-module fcc_axil_wr_ctrl contains the AW/W join FSM and B channel. It outputs a commit strobe, word index, data and strobes. The read path and register array stay in the top level.

## Test plan
- Reset held 500 ns, then write words 0–3 with 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011. Each read-back matches, and every BRESP/RRESP = 00.
- W presented 3 cycles before AW, with data 0x12345678 to word 1. Commit occurs on AW arrival, BVALID rises the next cycle, word 1 = 0x12345678, and cfg_update is exactly one pulse.
- Word 2 = 0xFFFFFFFF, then write 0x00000000 with WSTRB=0101. Read returns 0xFF00FF00.
- BREADY held low for 5 cycles. BVALID stays high; AWREADY and WREADY stay low; a second AW is not accepted until the B handshake.
- Pulse core_done, then read word 4 twice. Results are 0x2 then 0x0. With core_busy=1, bit0 reads 1. A core_done coinciding with the clearing read leaves the sticky bit set.
- Assert ARESETN low while BVALID and RVALID are pending. Both drop immediately; registers read 0 after release; a read of word 6 returns 0 with OKAY.
